// File: rtl/bayes_infer_seq.sv
// Sequential Bayes-inference driver: writes four observations to a chip-control
// AXI-lite slave, accumulates per-class byte scores from repeated reads, and reports the argmax.
module bayes_infer_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ACC_W     = 16,
    parameter int          ITER_W    = 8,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [35:0]          cmd_obs,
    input  logic [ITER_W-1:0]    cmd_n_iter,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*ACC_W-1:0]   res_sum,
    output logic [1:0]           res_class,
    output logic                 res_err,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [31:0]          aw_addr,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [31:0]          w_data,
    output logic [3:0]           w_strb,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [1:0]           b_resp,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [31:0]          ar_addr,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [31:0]          r_data,
    input  logic [1:0]           r_resp
);

    localparam int          WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [31:0] WR_BASE = BASE_ADDR + 32'h200C;
    localparam logic [31:0] RD_ADDR = BASE_ADDR + 32'h2000;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ARGMAX, DONE
    } state_t;

    state_t             r_state, w_next;
    logic [35:0]        r_obs;
    logic [ITER_W-1:0]  r_n_iter;
    logic [ITER_W-1:0]  r_rd_cnt;
    logic [1:0]         r_wr_idx;
    logic               r_aw_done;
    logic               r_w_done;
    logic [WAIT_W-1:0]  r_wait;
    logic [ACC_W-1:0]   r_acc [4];
    logic [1:0]         r_class;
    logic               r_err;

    logic               w_aw_hs, w_w_hs, w_addr_ok, w_data_ok;
    logic               w_timeout, w_in_wait, w_rd_last;
    logic [8:0]         w_obs_sel;
    logic [1:0]         w_best;
    logic [ACC_W-1:0]   w_best_val;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W + 1)'(b);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    assign w_aw_hs   = aw_valid & aw_ready;
    assign w_w_hs    = w_valid & w_ready;
    assign w_addr_ok = r_aw_done | w_aw_hs;
    assign w_data_ok = r_w_done | w_w_hs;
    assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_in_wait = (r_state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP});
    assign w_rd_last = ((r_rd_cnt + ITER_W'(1)) == r_n_iter);

    // Every bus output is decoded from registered state, so reset clears them without waiting for a clock.
    assign cmd_ready = rst_n && (r_state == IDLE);
    assign aw_valid  = (r_state == WR_REQ) && !r_aw_done;
    assign w_valid   = (r_state == WR_REQ) && !r_w_done;
    assign aw_addr   = (r_state == WR_REQ) ? WR_BASE + {28'b0, r_wr_idx, 2'b00} : '0;
    assign w_data    = (r_state == WR_REQ) ? {23'b0, w_obs_sel} : '0;
    assign w_strb    = (r_state == WR_REQ) ? 4'hF : 4'h0;
    assign b_ready   = (r_state == WR_RESP);
    assign ar_valid  = (r_state == RD_REQ);
    assign ar_addr   = (r_state == RD_REQ) ? RD_ADDR : '0;
    assign r_ready   = (r_state == RD_RESP);
    assign res_valid = (r_state == DONE);
    assign res_sum   = {r_acc[3], r_acc[2], r_acc[1], r_acc[0]};
    assign res_class = r_class;
    assign res_err   = r_err;

    always_comb begin
        case (r_wr_idx)
            2'd0:    w_obs_sel = r_obs[8:0];
            2'd1:    w_obs_sel = r_obs[17:9];
            2'd2:    w_obs_sel = r_obs[26:18];
            default: w_obs_sel = r_obs[35:27];
        endcase
    end

    // Strict greater-than keeps ties on the lowest class index.
    always_comb begin
        w_best     = 2'd0;
        w_best_val = r_acc[0];
        for (int k = 1; k < 4; k++) begin
            if (r_acc[k] > w_best_val) begin
                w_best     = 2'(k);
                w_best_val = r_acc[k];
            end
        end
    end

    // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_next = WR_REQ;
            WR_REQ: begin
                if (w_addr_ok && w_data_ok) w_next = WR_RESP;
                else if (w_timeout)         w_next = ARGMAX;
            end
            WR_RESP: begin
                if (b_valid) begin
                    if (b_resp != 2'b00)     w_next = ARGMAX;
                    else if (r_wr_idx != 2'd3) w_next = WR_REQ;
                    else if (r_n_iter == '0) w_next = ARGMAX;
                    else                     w_next = RD_REQ;
                end else if (w_timeout) begin
                    w_next = ARGMAX;
                end
            end
            RD_REQ: begin
                if (ar_ready)       w_next = RD_RESP;
                else if (w_timeout) w_next = ARGMAX;
            end
            RD_RESP: begin
                if (r_valid) w_next = (r_resp != 2'b00 || w_rd_last) ? ARGMAX : RD_REQ;
                else if (w_timeout) w_next = ARGMAX;
            end
            ARGMAX:  w_next = DONE;
            DONE:    if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_wait <= '0;
        else if (!w_in_wait || w_next != r_state) r_wait <= '0;
        else                                     r_wait <= r_wait + WAIT_W'(1);
    end

    // NOTE: the accumulator array is reset explicitly because res_sum must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_obs     <= '0;
            r_n_iter  <= '0;
            r_rd_cnt  <= '0;
            r_wr_idx  <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_class   <= '0;
            r_err     <= 1'b0;
            for (int k = 0; k < 4; k++) r_acc[k] <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_obs    <= cmd_obs;
                    r_n_iter <= cmd_n_iter;
                    r_rd_cnt <= '0;
                    r_wr_idx <= '0;
                    r_class  <= '0;
                    r_err    <= 1'b0;
                    for (int k = 0; k < 4; k++) r_acc[k] <= '0;
                end
                WR_REQ: begin
                    if (w_next != WR_REQ) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                    if (w_next == ARGMAX) r_err <= 1'b1;
                end
                WR_RESP: begin
                    if (b_valid) begin
                        if (b_resp != 2'b00) r_err    <= 1'b1;
                        else                 r_wr_idx <= r_wr_idx + 2'd1;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                RD_REQ: if (!ar_ready && w_timeout) r_err <= 1'b1;
                RD_RESP: begin
                    if (r_valid) begin
                        if (r_resp != 2'b00) begin
                            r_err <= 1'b1;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + ITER_W'(1);
                            for (int k = 0; k < 4; k++) r_acc[k] <= sat_add(r_acc[k], r_data[8*k +: 8]);
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                ARGMAX:  r_class <= w_best;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bayes_infer_seq.sv
// Self-checking bench for bayes_infer_seq: reactive AXI-lite slave, vector table,
// hand-written timeout/reset sequences and randomized runs against a score model.
module tb_bayes_infer_seq;

    localparam int ACC_W   = 12;
    localparam int ITER_W  = 8;
    localparam int TIMEOUT = 1024;
    localparam int MAXV    = (1 << ACC_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [35:0]         cmd_obs = '0;
    logic [ITER_W-1:0]   cmd_n_iter = '0;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [4*ACC_W-1:0]  res_sum;
    logic [1:0]          res_class;
    logic                res_err;
    logic                aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [31:0]         aw_addr, w_data, ar_addr;
    logic [3:0]          w_strb;
    logic                aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0, ar_ready = 1'b0, r_valid = 1'b0;
    logic [1:0]          b_resp = '0, r_resp = '0;
    logic [31:0]         r_data = '0;

    always #5 clk = ~clk;

    bayes_infer_seq #(
        .BASE_ADDR(32'h0), .ACC_W(ACC_W), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_obs(cmd_obs), .cmd_n_iter(cmd_n_iter),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_class(res_class), .res_err(res_err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave configuration (written by the main sequence only).
    bit          stall = 1'b0;
    bit          ar_block = 1'b0;
    int          err_wr = -1;
    int          err_rd = -1;
    int          r_delay_min = 0;
    logic [31:0] rdata_arr [256];

    // Slave observations (written by the slave only).
    logic [31:0] aw_log [$];
    logic [31:0] w_log [$];
    int          ar_cnt, addr_bad, strb_bad;

    // Slave: all decisions at the falling edge; a handshake seen here completes at the next rising edge.
    initial begin
        bit aw_got, w_got, b_pend, r_pend;
        int b_wait, r_wait, wr_i, rd_i;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
                ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                b_wait = 0; r_wait = 0; wr_i = 0; rd_i = 0;
                aw_log.delete(); w_log.delete();
                ar_cnt = 0; addr_bad = 0; strb_bad = 0;
            end else begin
                if (b_pend) begin b_valid = 0; b_resp = 0; b_pend = 0; end
                if (r_pend) begin r_valid = 0; r_resp = 0; r_data = 0; r_pend = 0; end
                if (b_wait > 0) begin
                    b_wait--;
                    if (b_wait == 0) begin
                        b_valid = 1; b_resp = (wr_i == err_wr) ? 2'b10 : 2'b00; wr_i++;
                    end
                end
                if (r_wait > 0) begin
                    r_wait--;
                    if (r_wait == 0) begin
                        r_valid = 1; r_data = rdata_arr[rd_i[7:0]];
                        r_resp = (rd_i == err_rd) ? 2'b10 : 2'b00; rd_i++;
                    end
                end
                if (b_valid && b_ready) b_pend = 1;
                if (r_valid && r_ready) r_pend = 1;
                aw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                ar_ready = ar_block ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
                if (aw_valid && aw_ready) begin aw_log.push_back(aw_addr); aw_got = 1; end
                if (w_valid && w_ready) begin
                    w_log.push_back(w_data); w_got = 1;
                    if (w_strb != 4'hF) strb_bad++;
                end
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0;
                    b_wait = 1 + (stall ? int'($urandom_range(0, 3)) : 0);
                end
                if (ar_valid && ar_ready) begin
                    ar_cnt++;
                    if (ar_addr != 32'h2000) addr_bad++;
                    r_wait = 1 + r_delay_min + (stall ? int'($urandom_range(0, 3)) : 0);
                end
            end
        end
    end

    // Reference model: expected outcome computed from the scoring rules, not from the FSM.
    int exp_sum [4];
    int exp_cls, exp_nwr, exp_nrd;
    bit exp_err;

    task automatic model(input int n);
        bit stop;
        stop = 0;
        for (int k = 0; k < 4; k++) exp_sum[k] = 0;
        exp_err = 0; exp_nrd = 0; exp_cls = 0;
        if (err_wr >= 0 && err_wr < 4) begin
            exp_nwr = err_wr + 1;
            exp_err = 1;
        end else begin
            exp_nwr = 4;
            for (int i = 0; i < n; i++) begin
                if (!stop) begin
                    exp_nrd++;
                    if (i == err_rd) begin
                        exp_err = 1; stop = 1;
                    end else begin
                        for (int k = 0; k < 4; k++) begin
                            exp_sum[k] += int'(rdata_arr[i][8*k +: 8]);
                            if (exp_sum[k] > MAXV) exp_sum[k] = MAXV;
                        end
                    end
                end
            end
        end
        for (int k = 1; k < 4; k++) if (exp_sum[k] > exp_sum[exp_cls]) exp_cls = k;
    endtask

    task automatic do_reset();
        rst_n = 0; cmd_valid = 0; res_ready = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic issue(input logic [35:0] obs, input logic [7:0] n);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_obs = obs; cmd_n_iter = n; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_res(input int budget);
        int cyc;
        cyc = 0;
        while (!res_valid && cyc < budget) begin @(negedge clk); cyc++; end
        check("res_valid_seen", res_valid, 1);
    endtask

    task automatic compare_result();
        for (int k = 0; k < 4; k++) check($sformatf("sum%0d", k), 64'(res_sum[k*ACC_W +: ACC_W]), 64'(exp_sum[k]));
        check("res_class", res_class, 64'(exp_cls));
        check("res_err", res_err, 64'(exp_err));
    endtask

    task automatic compare_bus(input logic [35:0] obs);
        logic [31:0] want;
        check("aw_count", aw_log.size(), exp_nwr);
        check("w_count", w_log.size(), exp_nwr);
        for (int i = 0; i < 4; i++) begin
            if (i < aw_log.size() && i < w_log.size()) begin
                want = 32'h200C + 32'(4 * i);
                check($sformatf("aw_addr%0d", i), aw_log[i], want);
                want = {23'b0, obs[9*i +: 9]};
                check($sformatf("w_data%0d", i), w_log[i], want);
            end
        end
        check("ar_count", ar_cnt, exp_nrd);
        check("ar_addr_bad", addr_bad, 0);
        check("w_strb_bad", strb_bad, 0);
    endtask

    task automatic release_res();
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        check("idle_after_done", {res_valid, cmd_ready}, 2'b01);
    endtask

    task automatic run_txn(input logic [35:0] obs, input logic [7:0] n, input int hold);
        logic [4*ACC_W-1:0] s;
        logic [1:0]         c;
        logic               e;
        bit                 changed;
        do_reset();
        issue(obs, n);
        wait_res(5000);
        compare_result();
        compare_bus(obs);
        if (hold > 0) begin
            s = res_sum; c = res_class; e = res_err; changed = 0;
            repeat (hold) begin
                @(negedge clk);
                if (res_sum !== s || res_class !== c || res_err !== e || res_valid !== 1'b1) changed = 1;
            end
            check("hold_stable", changed, 0);
        end
        release_res();
    endtask

    typedef struct packed {
        logic [35:0] obs;
        logic [7:0]  n_iter;
        logic [31:0] rdata;
        int          err_wr;
        int          err_rd;
        int          hold;
        logic [63:0] exp_sum;   // {class3, class2, class1, class0}, 16 bits each
        logic [1:0]  exp_cls;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit seen;
        int cnt;
        logic [35:0] robs;

        vecs[0] = '{obs: {9'h0FF, 9'h100, 9'h005, 9'h1A3}, n_iter: 8'd3, rdata: 32'h04030201,
                    err_wr: -1, err_rd: -1, hold: 0,
                    exp_sum: {16'd12, 16'd9, 16'd6, 16'd3}, exp_cls: 2'd3, exp_err: 1'b0};
        vecs[1] = '{obs: {9'h011, 9'h022, 9'h033, 9'h044}, n_iter: 8'd1, rdata: 32'h05050505,
                    err_wr: -1, err_rd: -1, hold: 10,
                    exp_sum: {16'd5, 16'd5, 16'd5, 16'd5}, exp_cls: 2'd0, exp_err: 1'b0};
        vecs[2] = '{obs: {9'h1FF, 9'h000, 9'h1FF, 9'h000}, n_iter: 8'd255, rdata: 32'hFF000000,
                    err_wr: -1, err_rd: -1, hold: 0,
                    exp_sum: {16'd4095, 16'd0, 16'd0, 16'd0}, exp_cls: 2'd3, exp_err: 1'b0};
        vecs[3] = '{obs: {9'h123, 9'h045, 9'h067, 9'h189}, n_iter: 8'd0, rdata: 32'h11223344,
                    err_wr: -1, err_rd: -1, hold: 0,
                    exp_sum: 64'd0, exp_cls: 2'd0, exp_err: 1'b0};
        vecs[4] = '{obs: {9'h004, 9'h003, 9'h002, 9'h001}, n_iter: 8'd3, rdata: 32'h01010101,
                    err_wr: 1, err_rd: -1, hold: 0,
                    exp_sum: 64'd0, exp_cls: 2'd0, exp_err: 1'b1};
        vecs[5] = '{obs: {9'h0AA, 9'h155, 9'h0F0, 9'h10F}, n_iter: 8'd4, rdata: 32'h01020304,
                    err_wr: -1, err_rd: 1, hold: 0,
                    exp_sum: {16'd1, 16'd2, 16'd3, 16'd4}, exp_cls: 2'd0, exp_err: 1'b1};
        vecs[6] = '{obs: {9'h001, 9'h002, 9'h004, 9'h008}, n_iter: 8'd2, rdata: 32'h07070303,
                    err_wr: -1, err_rd: -1, hold: 0,
                    exp_sum: {16'd14, 16'd14, 16'd6, 16'd6}, exp_cls: 2'd2, exp_err: 1'b0};

        // Reset values
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_valids", {aw_valid, w_valid, ar_valid}, 3'b000);
        check("rst_readies", {b_ready, r_ready}, 2'b00);
        check("rst_res_sum", res_sum, 0);
        check("rst_class_err", {res_class, res_err}, 3'b000);
        check("rst_addr_data", {aw_addr, ar_addr}, 64'd0);
        check("rst_wdata_strb", {w_data, w_strb}, 36'd0);
        #2 rst_n = 1;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            stall = 0; ar_block = 0; r_delay_min = 0;
            err_wr = vecs[v].err_wr; err_rd = vecs[v].err_rd;
            for (int i = 0; i < 256; i++) rdata_arr[i] = vecs[v].rdata;
            model(int'(vecs[v].n_iter));
            for (int k = 0; k < 4; k++) exp_sum[k] = int'(vecs[v].exp_sum[16*k +: 16]);
            exp_cls = int'(vecs[v].exp_cls);
            exp_err = vecs[v].exp_err;
            run_txn(vecs[v].obs, vecs[v].n_iter, vecs[v].hold);
        end

        // Read address never accepted: ar_valid held exactly TIMEOUT cycles, then error result
        stall = 0; err_wr = -1; err_rd = -1; ar_block = 1;
        for (int i = 0; i < 256; i++) rdata_arr[i] = 32'h01010101;
        do_reset();
        issue(36'h0_1234_5678, 8'd2);
        cnt = 0;
        while (!ar_valid && cnt < 200) begin @(negedge clk); cnt++; end
        check("ar_valid_rise", ar_valid, 1);
        cnt = 0;
        while (ar_valid && cnt < 3000) begin cnt++; @(negedge clk); end
        check("ar_valid_cycles", cnt, TIMEOUT);
        wait_res(50);
        for (int k = 0; k < 4; k++) exp_sum[k] = 0;
        exp_cls = 0; exp_err = 1;
        compare_result();
        check("timeout_ar_count", ar_cnt, 0);
        release_res();
        ar_block = 0;

        // Reset pulsed while waiting for read data
        r_delay_min = 30;
        do_reset();
        issue(36'h0_0000_0001, 8'd3);
        cnt = 0;
        while (!r_ready && cnt < 200) begin @(negedge clk); cnt++; end
        check("r_ready_rise", r_ready, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst_r_ready", r_ready, 0);
        check("midrst_valids", {aw_valid, w_valid, ar_valid, res_valid}, 4'b0000);
        check("midrst_cmd_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("cmd_ready_after_release", cmd_ready, 1);
        seen = 0;
        repeat (50) begin @(negedge clk); if (res_valid) seen = 1; end
        check("no_res_after_abort", seen, 0);
        r_delay_min = 0;

        // Randomized runs with stalling slave and occasional error responses
        for (int t = 0; t < 30; t++) begin
            stall = 1; ar_block = 0; r_delay_min = 0;
            err_wr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            err_rd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            for (int i = 0; i < 256; i++) rdata_arr[i] = $urandom;
            robs = {4'($urandom), $urandom};
            cnt = int'($urandom_range(0, 8));
            model(cnt);
            run_txn(robs, 8'(cnt), (t % 5 == 0) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
